// File: rtl/decoder_scan_driver_pkg.sv
// Shared types and constants for the decoder scan driver and its timer.
package decoder_scan_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  // Index of the last decoder line in a frame
  localparam logic [1:0] SLOT_LAST = 2'd3;

  // Default widths for the dwell input/counter and the frame counter
  localparam int DWELL_W_DEF = 8;
  localparam int FRAME_W_DEF = 8;

endpackage : decoder_scan_pkg

// File: rtl/decoder_scan_driver_scan_timer.sv
// Loadable down-counter shared by dwell and blank timing.
// A phase of length L is timed by loading L-1; the phase ends on the
// cycle where o_zero is high.
module scan_timer
  import decoder_scan_pkg::*;
#(
  parameter int W = DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule : scan_timer

// File: rtl/decoder_scan_driver.sv
// Walks the 2-to-4 decoder selects through slots 0..3, holding the decoder
// enable high for a latched dwell per slot with enable-low gaps between
// slots so the selects only move while the decoder is disabled.
module decoder_scan_driver
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W      = DWELL_W_DEF,
  parameter int BLANK_CYCLES = 2,
  parameter int FRAME_W      = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               E,
  output logic               I0,
  output logic               I1,
  output logic [1:0]         slot,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Timer must hold both dwell-1 and BLANK_CYCLES-1
  localparam int BLANK_LOAD_W = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES);
  localparam int TIMER_W      = (DWELL_W > BLANK_LOAD_W) ? DWELL_W : BLANK_LOAD_W;
  localparam int BLANK_LOAD_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_LOAD_I);
  localparam bit HAS_BLANK    = (BLANK_CYCLES > 0);

  // Registered state and outputs
  scan_state_e        r_state;
  logic [1:0]         r_slot;
  logic               r_mode;
  logic [DWELL_W-1:0] r_dwell_m1;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_e;
  logic               r_busy;
  logic               r_done;

  // Next-state and control
  scan_state_e        w_state_next;
  logic [1:0]         w_slot_next;
  logic [FRAME_W-1:0] w_frame_next;
  logic               w_accept;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_zero;
  logic [DWELL_W-1:0] w_dwell_m1;

  // Where the scan goes after a slot has finished (dwell plus any blank)
  scan_state_e        w_adv_state;
  logic [1:0]         w_adv_slot;
  logic [FRAME_W-1:0] w_adv_frame;

  // A zero dwell is promoted to one cycle, so its load value is also zero
  assign w_dwell_m1 = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

  scan_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Slot advance: wrap after the last slot, counting the frame
  always_comb begin
    w_adv_state = ST_ACTIVE;
    w_adv_slot  = r_slot + 2'd1;
    w_adv_frame = r_frame_cnt;
    if (r_slot == SLOT_LAST) begin
      w_adv_slot  = 2'd0;
      w_adv_frame = r_frame_cnt + FRAME_W'(1);
      w_adv_state = r_mode ? ST_ACTIVE : ST_DONE;
    end
  end

  // Sequencer next-state logic; stop wins over every other transition
  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    w_frame_next = r_frame_cnt;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_load_val   = TIMER_W'(r_dwell_m1);
    unique case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_accept     = 1'b1;
          w_state_next = ST_ACTIVE;
          w_slot_next  = 2'd0;
          w_frame_next = '0;
          w_load       = 1'b1;
          w_load_val   = TIMER_W'(w_dwell_m1);
        end
      end
      ST_ACTIVE: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_zero) begin
          if (HAS_BLANK) begin
            w_state_next = ST_BLANK;
            w_load       = 1'b1;
            w_load_val   = BLANK_LOAD;
          end else begin
            // No blanking: selects move while enable stays high
            w_state_next = w_adv_state;
            w_slot_next  = w_adv_slot;
            w_frame_next = w_adv_frame;
            w_load       = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_zero) begin
          w_state_next = w_adv_state;
          w_slot_next  = w_adv_slot;
          w_frame_next = w_adv_frame;
          w_load       = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, latched configuration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_slot      <= 2'd0;
      r_mode      <= 1'b0;
      r_dwell_m1  <= '0;
      r_frame_cnt <= '0;
      r_e         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_slot      <= w_slot_next;
      r_frame_cnt <= w_frame_next;
      r_e         <= (w_state_next == ST_ACTIVE);
      r_busy      <= (w_state_next != ST_IDLE);
      r_done      <= (w_state_next == ST_DONE);
      if (w_accept) begin
        r_dwell_m1 <= w_dwell_m1;
        r_mode     <= mode;
      end
    end
  end

  assign E         = r_e;
  assign I0        = r_slot[0];
  assign I1        = r_slot[1];
  assign slot      = r_slot;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule : decoder_scan_driver

// File: tb/tb_decoder_scan_driver.sv
// Directed bench for decoder_scan_driver with BLANK_CYCLES=2.
module tb_decoder_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] dwell;
  logic       E;
  logic       I0;
  logic       I1;
  logic [1:0] slot;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_scan_driver #(
    .DWELL_W      (8),
    .BLANK_CYCLES (2),
    .FRAME_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .E         (E),
    .I0        (I0),
    .I1        (I1),
    .slot      (slot),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int exp_slot, input int exp_frames);
    logic [1:0] s;
    s = exp_slot[1:0];
    check({tag, "_E"}, E, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_slot"}, slot, s);
    check({tag, "_I0"}, I0, s[0]);
    check({tag, "_I1"}, I1, s[1]);
    check({tag, "_frame"}, frame_cnt, exp_frames);
  endtask

  // One single-frame scan; per = effective dwell + 2 blank cycles
  task automatic run_single(input int dwell_in, input int dq, input bit disturb);
    int per;
    int len;
    int pos;
    int s;
    per   = dq + 2;
    len   = 4 * per;
    dwell = dwell_in[7:0];
    mode  = 1'b0;
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= len; k++) begin
      pos = k - 1;
      s   = pos / per;
      check("sf_E", E, ((pos % per) < dq) ? 1 : 0);
      check("sf_slot", slot, s);
      check("sf_I0", I0, s % 2);
      check("sf_I1", I1, s / 2);
      check("sf_busy", busy, 1);
      check("sf_done", done, 0);
      if (disturb && k == 2) begin
        start = 1'b1;
        dwell = 8'd7;
        mode  = 1'b1;
      end
      if (disturb && k == 3) start = 1'b0;
      tick();
    end
    check("sf_done_pulse", done, 1);
    check("sf_done_busy", busy, 1);
    check("sf_done_E", E, 0);
    check("sf_done_frame", frame_cnt, 1);
    check("sf_done_slot", slot, 0);
    tick();
    check_idle("sf_after", 0, 1);
    $display("single frame dwell=%0d disturb=%0d: %0d cycles busy", dwell_in, disturb, len + 1);
  endtask

  initial begin
    int pos;
    int s;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    dwell = 8'd3;

    // Reset held for two cycles, then idle
    tick();
    tick();
    check_idle("rst", 0, 0);
    rst = 1'b0;
    tick();
    tick();
    check_idle("idle", 0, 0);
    $display("reset/idle done");

    // Single frame, dwell 3
    run_single(3, 3, 1'b0);

    // Dwell zero is treated as one cycle
    run_single(0, 1, 1'b0);

    // Ignore rules: start, dwell and mode changes while busy
    run_single(3, 3, 1'b1);

    // start and stop together in IDLE: stays idle
    dwell = 8'd3;
    mode  = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check_idle("ss", 0, 1);
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check_idle("ss2", 0, 1);
    $display("start+stop in idle ignored");

    // Continuous mode, dwell 2 (frame 16 cycles), stop in slot 1 of frame 4
    dwell = 8'd2;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 53; k++) begin
      pos = k - 1;
      s   = (pos % 16) / 4;
      check("ct_E", E, ((pos % 4) < 2) ? 1 : 0);
      check("ct_slot", slot, s);
      check("ct_frame", frame_cnt, pos / 16);
      check("ct_busy", busy, 1);
      check("ct_done", done, 0);
      if (k < 53) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("ct_stop", 1, 3);
    tick();
    check_idle("ct_stop2", 1, 3);
    $display("continuous stop after 3 frames");

    // Reset during the blank after slot 2
    dwell = 8'd3;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 14; k++) tick();
    check("mr_blank_E", E, 0);
    check("mr_blank_slot", slot, 2);
    check("mr_blank_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mr_rst", 0, 0);
    run_single(3, 3, 1'b0);
    $display("reset mid-scan then restart");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_decoder_scan_driver
